// File: rtl/board_io.sv
// board_io: synchronised, debounced board inputs with sticky edge events, and
// registered LED outputs with selectable polarity. Define BOARD_IO_PWM_EN for PWM dimming.
module board_io #(
  parameter int unsigned     IN_W       = 8,
  parameter int unsigned     OUT_W      = 8,
  parameter int unsigned     DB_LIMIT   = 50000,
  parameter int unsigned     DB_CW      = 16,
  parameter logic [IN_W-1:0] EV_RISE    = {IN_W{1'b1}},
  parameter logic [IN_W-1:0] EV_FALL    = {IN_W{1'b0}},
  parameter bit              OUT_INVERT = 1'b1,
  parameter int unsigned     PWM_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   pin_i,
  output logic [IN_W-1:0]   gp_i,
  output logic [IN_W-1:0]   ev_o,
  output logic [IN_W-1:0]   ev_ovf,
  input  logic [IN_W-1:0]   ev_clr,
  input  logic [OUT_W-1:0]  gp_o,
  input  logic [PWM_W-1:0]  duty,
  output logic [OUT_W-1:0]  pin_o
);

  localparam logic [DB_CW-1:0] LIMIT_M1 = DB_CW'(DB_LIMIT - 1);

  logic [IN_W-1:0]             s1_q, s2_q;
  logic [IN_W-1:0]             gp_q, gp_d;
  logic [IN_W-1:0][DB_CW-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]             ev_q, ev_d;
  logic [IN_W-1:0]             ovf_q, ovf_d;
  logic [IN_W-1:0]             set_s;
  logic [OUT_W-1:0]            lit_s;
  logic [OUT_W-1:0]            pin_q, pin_d;

  // Debounce: a level is accepted only after DB_LIMIT consecutive disagreeing samples.
  always_comb begin
    gp_d  = gp_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(IN_W); i++) begin
      if (s2_q[i] == gp_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LIMIT_M1) begin
        gp_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_CW'(1);
      end
    end
  end

  // Sticky events; a new event beats a simultaneous clear but does not flag overflow then.
  always_comb begin
    ev_d  = ev_q;
    ovf_d = ovf_q;
    set_s = (gp_d & ~gp_q & EV_RISE) | (~gp_d & gp_q & EV_FALL);
    for (int i = 0; i < int'(IN_W); i++) begin
      if (set_s[i]) begin
        ev_d[i] = 1'b1;
        if (!ev_clr[i]) begin
          ovf_d[i] = ovf_q[i] | ev_q[i];
        end else begin
          ovf_d[i] = ovf_q[i];
        end
      end else if (ev_clr[i]) begin
        ev_d[i]  = 1'b0;
        ovf_d[i] = 1'b0;
      end else begin
        ev_d[i]  = ev_q[i];
        ovf_d[i] = ovf_q[i];
      end
    end
  end

`ifdef BOARD_IO_PWM_EN
  logic [PWM_W-1:0] p_q, p_d;
  logic             on_s;

  // Free-running PWM phase; duty all-ones means fully on rather than one cycle short.
  always_comb begin
    p_d   = p_q + PWM_W'(1);
    on_s  = (duty == {PWM_W{1'b1}}) || (p_q < duty);
    lit_s = gp_o & {OUT_W{on_s}};
  end

  // PWM phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end
`else
  logic unused_duty_s;
  assign unused_duty_s = ^duty;

  // Without PWM the LEDs simply follow the MCU levels.
  always_comb begin
    lit_s = gp_o;
  end
`endif

  // Output polarity applied before the pin register.
  always_comb begin
    pin_d = lit_s ^ {OUT_W{OUT_INVERT}};
  end

  // All state registers; reset drives LEDs to their inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      gp_q  <= '0;
      cnt_q <= '0;
      ev_q  <= '0;
      ovf_q <= '0;
      pin_q <= {OUT_W{OUT_INVERT}};
    end else begin
      s1_q  <= pin_i;
      s2_q  <= s1_q;
      gp_q  <= gp_d;
      cnt_q <= cnt_d;
      ev_q  <= ev_d;
      ovf_q <= ovf_d;
      pin_q <= pin_d;
    end
  end

  assign gp_i   = gp_q;
  assign ev_o   = ev_q;
  assign ev_ovf = ovf_q;
  assign pin_o  = pin_q;

endmodule
